// File: rtl/spram_arb_pkg.sv
// Shared widths and FSM encoding for the frame SPRAM arbiter.
package spram_arb_pkg;

    localparam int ADDR_W  = 15;
    localparam int PIX_W   = 12;
    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } arb_state_e;

endpackage

// File: rtl/spram_rd_tag_pipe.sv
// RD_LAT-deep {valid, x} shift register aligning read tags with SPRAM returns.
module spram_rd_tag_pipe
    import spram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] in_x,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_x
);

    logic [RD_LAT-1:0]  valid_q;
    logic [COORD_W-1:0] x_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < unsigned'(RD_LAT); i++) begin
                x_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            x_q[0]     <= in_x;
            for (int unsigned i = 1; i < unsigned'(RD_LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                x_q[i]     <= x_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_x     = x_q[RD_LAT-1];

endmodule

// File: rtl/spram_arbiter.sv
// Frame SPRAM scheduler: ingest writes vs. display line fetch with guaranteed write slots.
// Optional stall/line statistics outputs when SPRAM_ARB_STATS_EN is defined.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int W        = 4,
    parameter int H        = 2,
    parameter int RD_BURST = 2,
    parameter int RD_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               wr_valid,
    input  logic [PIX_W-1:0]   wr_data,
    output logic               wr_ready,
    output logic               frame_done,
    input  logic               line_req,
    input  logic [COORD_W-1:0] line_y,
    output logic               line_busy,
    output logic               line_err,
    output logic               line_done,
    output logic               rd_valid,
    output logic [COORD_W-1:0] rd_x,
    output logic [PIX_W-1:0]   rd_data,
    output logic               mem_ce,
    output logic               mem_wre,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [PIX_W-1:0]   mem_wdata,
    input  logic [PIX_W-1:0]   mem_rdata
`ifdef SPRAM_ARB_STATS_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        line_cnt
`endif
);

    localparam int BC_W = $clog2(RD_BURST + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W * H - 1);

    arb_state_e         state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q;
    logic [BC_W-1:0]    bc_q, bc_d;
    logic [1:0]         dc_q, dc_d;
    logic [ADDR_W-1:0]  ptr_q, addr_q, wr_addr, rd_addr;
    logic [PIX_W-1:0]   wdata_q;
    logic               live_q, line_err_q;
    logic               wr_go, rd_go, slot, accept, reject, y_ok;

    // live_q keeps wr_ready low for the first cycle out of reset without a path from rst
    assign slot     = (bc_q == BC_W'(RD_BURST));
    assign wr_ready = live_q && ((state_q != FETCH) || slot);
    assign wr_go    = wr_valid && wr_ready;
    assign rd_go    = (state_q == FETCH) && !slot;

    assign wr_addr  = frame_start ? '0 : ptr_q;
    assign rd_addr  = ADDR_W'(y_q) * ADDR_W'(W) + ADDR_W'(x_q);

    assign mem_ce     = wr_go || rd_go;
    assign mem_wre    = wr_go;
    assign mem_addr   = wr_go ? wr_addr : (rd_go ? rd_addr : addr_q);
    assign mem_wdata  = wr_go ? wr_data : wdata_q;
    assign frame_done = wr_go && (wr_addr == LAST_ADDR);

    assign y_ok   = (32'(line_y) < 32'(H));
    assign accept = (state_q == IDLE) && line_req && y_ok;
    assign reject = (state_q == IDLE) && line_req && !y_ok;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        bc_d    = bc_q;
        dc_d    = dc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FETCH;
                    x_d     = '0;
                    bc_d    = '0;
                end
            end
            FETCH: begin
                if (rd_go) begin
                    x_d  = x_q + 1'b1;
                    bc_d = bc_q + 1'b1;
                    if (x_q == COORD_W'(W - 1)) begin
                        state_d = DRAIN;
                        x_d     = '0;
                        bc_d    = '0;
                        dc_d    = '0;
                    end
                end else begin
                    bc_d = '0;
                end
            end
            DRAIN: begin
                if (dc_q == 2'(RD_LAT - 1)) begin
                    state_d = IDLE;
                end else begin
                    dc_d = dc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            bc_q       <= '0;
            dc_q       <= '0;
            ptr_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            live_q     <= 1'b0;
            line_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            bc_q       <= bc_d;
            dc_q       <= dc_d;
            live_q     <= 1'b1;
            line_err_q <= reject;
            if (accept) begin
                y_q <= line_y;
            end
            if (wr_go) begin
                ptr_q   <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
                wdata_q <= wr_data;
            end else if (frame_start) begin
                ptr_q <= '0;
            end
            if (mem_ce) begin
                addr_q <= mem_addr;
            end
        end
    end

    spram_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_go),
        .in_x      (rd_go ? x_q : '0),
        .out_valid (rd_valid),
        .out_x     (rd_x)
    );

    assign rd_data   = rd_valid ? mem_rdata : '0;
    assign line_done = rd_valid && (rd_x == COORD_W'(W - 1));
    assign line_busy = (state_q != IDLE);
    assign line_err  = line_err_q;

`ifdef SPRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            line_cnt  <= '0;
        end else begin
            if (frame_start) begin
                stall_cnt <= '0;
            end else if (wr_valid && !wr_ready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (line_done && line_cnt != 16'hFFFF) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter (W=4, H=2, RD_BURST=2, RD_LAT=1).
module tb_spram_arbiter;

    logic        clk = 1'b0;
    logic        rst, frame_start, wr_valid, line_req;
    logic [11:0] wr_data;
    logic [9:0]  line_y;
    logic        wr_ready, frame_done, line_busy, line_err, line_done, rd_valid;
    logic [9:0]  rd_x;
    logic [11:0] rd_data, mem_wdata, mem_rdata;
    logic        mem_ce, mem_wre;
    logic [14:0] mem_addr;
`ifdef SPRAM_ARB_STATS_EN
    logic [15:0] stall_cnt, line_cnt;
`endif

    spram_arbiter #(.W(4), .H(2), .RD_BURST(2), .RD_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .frame_done (frame_done),
        .line_req   (line_req),
        .line_y     (line_y),
        .line_busy  (line_busy),
        .line_err   (line_err),
        .line_done  (line_done),
        .rd_valid   (rd_valid),
        .rd_x       (rd_x),
        .rd_data    (rd_data),
        .mem_ce     (mem_ce),
        .mem_wre    (mem_wre),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef SPRAM_ARB_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .line_cnt   (line_cnt)
`endif
    );

    always #5 clk = ~clk;

    // SPRAM macro model, 1-cycle read latency
    logic [11:0] ram [32];
    always @(posedge clk) begin
        if (mem_ce && mem_wre) ram[mem_addr[4:0]] <= mem_wdata;
        else if (mem_ce)       mem_rdata <= ram[mem_addr[4:0]];
    end

    typedef struct { logic wre; logic [14:0] addr; logic [11:0] data; } acc_t;
    typedef struct { logic [9:0] x; logic [11:0] data; logic done; } ret_t;
    acc_t acc_q[$];
    ret_t ret_q[$];
    logic [11:0] shadow [32];
    int ptr_m = 0;
    int nchk = 0, npass = 0;
    bit mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [11:0] d);
        acc_q.push_back('{wre: 1'b1, addr: 15'(ptr_m), data: d});
        shadow[ptr_m] = d;
        ptr_m = (ptr_m == 7) ? 0 : ptr_m + 1;
    endtask

    task automatic push_rd(input int addr, input int x);
        acc_q.push_back('{wre: 1'b0, addr: 15'(addr), data: 12'h0});
        ret_q.push_back('{x: 10'(x), data: shadow[addr], done: (x == 3)});
    endtask

    always @(negedge clk) begin
        if (mon_en && mem_ce === 1'b1) begin
            chk("acc_expected", acc_q.size() != 0, 1);
            if (acc_q.size() != 0) begin
                acc_t a;
                a = acc_q.pop_front();
                chk("mem_wre", mem_wre, a.wre);
                chk("mem_addr", mem_addr, a.addr);
                if (a.wre) chk("mem_wdata", mem_wdata, a.data);
            end
        end
        if (mon_en && rd_valid === 1'b1) begin
            chk("ret_expected", ret_q.size() != 0, 1);
            if (ret_q.size() != 0) begin
                ret_t r;
                r = ret_q.pop_front();
                chk("rd_x", rd_x, r.x);
                chk("rd_data", rd_data, r.data);
                chk("line_done", line_done, r.done);
            end
        end
    end

    // Cycle k relative to line_req: ready/read/busy/return patterns, bit k = cycle k
    task automatic run_fetch(input int y, input bit wv, input logic [11:0] base);
        logic [7:0] rdy_b, rd_b, busy_b, rv_b, done_b;
        int xi;
        rdy_b  = 8'b1100_1001;
        rd_b   = 8'b0011_0110;
        busy_b = 8'b0111_1110;
        rv_b   = 8'b0110_1100;
        done_b = 8'b0100_0000;
        xi = 0;
        for (int k = 0; k < 8; k++) begin
            line_req = (k == 0) || (k == 2);
            line_y   = (k == 0) ? 10'(y) : 10'd0;
            wr_valid = wv;
            wr_data  = base + 12'(k);
            if (wv && rdy_b[k]) push_wr(wr_data);
            if (rd_b[k]) begin
                push_rd(y * 4 + xi, xi);
                xi++;
            end
            @(negedge clk);
            chk("wr_ready", wr_ready, rdy_b[k]);
            chk("line_busy", line_busy, busy_b[k]);
            chk("rd_valid", rd_valid, rv_b[k]);
            chk("line_done_t", line_done, done_b[k]);
            chk("mem_ce", mem_ce, rd_b[k] | (wv & rdy_b[k]));
            chk("line_err_0", line_err, 0);
            step();
        end
        line_req = 0;
        wr_valid = 0;
    endtask

    task automatic chk_all_zero();
        chk("z_wr_ready", wr_ready, 0);
        chk("z_mem_ce", mem_ce, 0);
        chk("z_mem_wre", mem_wre, 0);
        chk("z_mem_addr", mem_addr, 0);
        chk("z_mem_wdata", mem_wdata, 0);
        chk("z_rd_valid", rd_valid, 0);
        chk("z_rd_x", rd_x, 0);
        chk("z_rd_data", rd_data, 0);
        chk("z_line_busy", line_busy, 0);
        chk("z_line_err", line_err, 0);
        chk("z_line_done", line_done, 0);
        chk("z_frame_done", frame_done, 0);
    endtask

    initial begin
        rst = 1; frame_start = 0; wr_valid = 0; line_req = 0;
        wr_data = 0; line_y = 0;
        repeat (3) step();
        rst = 0;
        mon_en = 1;
        @(negedge clk);
        chk_all_zero();
        step();

        // eight writes fill the frame, frame_done on the last, then wrap to 0
        for (int i = 1; i <= 9; i++) begin
            bit fd;
            fd = (ptr_m == 7);
            wr_valid = 1;
            wr_data  = (i == 9) ? 12'h0AA : 12'(i);
            push_wr(wr_data);
            @(negedge clk);
            chk("frame_done", frame_done, fd);
            chk("wr_ready_w", wr_ready, 1);
            step();
        end
        wr_valid = 0;
        step();

        run_fetch(1, 0, 12'h000);
        step();
        run_fetch(1, 1, 12'h100);
`ifdef SPRAM_ARB_STATS_EN
        chk("stall_cnt", stall_cnt, 4);
        chk("line_cnt", line_cnt, 2);
`endif
        step();

        // out-of-range line is rejected with a line_err pulse
        line_req = 1; line_y = 10'd2;
        @(negedge clk);
        chk("bad_ce0", mem_ce, 0);
        step();
        line_req = 0; line_y = 0;
        @(negedge clk);
        chk("line_err", line_err, 1);
        chk("bad_busy", line_busy, 0);
        chk("bad_ce1", mem_ce, 0);
        step();
        @(negedge clk);
        chk("line_err_end", line_err, 0);
        step();

        // reset in the write slot of a line-0 fetch
        line_req = 1; line_y = 0;
        step();
        line_req = 0;
        push_rd(0, 0);
        step();
        push_rd(1, 1);
        step();
        rst = 1;
        @(negedge clk);
        chk("rst_rv_before", rd_valid, 1);
        step();
        rst = 0;
        ptr_m = 0;
        @(negedge clk);
        chk_all_zero();
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_rv", rd_valid, 0);
            chk("post_rst_busy", line_busy, 0);
            step();
        end
        run_fetch(1, 0, 12'h000);
        step();

        // frame_start alone rewinds; with a transfer the write lands at 0
        wr_valid = 1; wr_data = 12'h2A0; push_wr(wr_data);
        step();
        wr_valid = 0; frame_start = 1; ptr_m = 0;
        step();
        frame_start = 0; wr_valid = 1; wr_data = 12'h2A1; push_wr(wr_data);
        @(negedge clk);
`ifdef SPRAM_ARB_STATS_EN
        chk("stall_clr", stall_cnt, 0);
`endif
        step();
        frame_start = 1; wr_data = 12'h2A2; ptr_m = 0; push_wr(wr_data);
        step();
        frame_start = 0; wr_data = 12'h2A3; push_wr(wr_data);
        step();
        wr_valid = 0;
        repeat (3) step();

        chk("acc_q_drained", acc_q.size(), 0);
        chk("ret_q_drained", ret_q.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
